// File: rtl/sonic_echo_responder.sv
// Ultrasonic ranging sensor emulator: qualifies a trigger pulse, waits out the burst, answers with a distance-proportional echo.
// Optional macro SONIC_ECHO_TIMEOUT_EN: out-of-range distances answer with a full-length no-target echo instead of none.
module sonic_echo_responder #(
  parameter int unsigned TRIG_MIN_CYC = 1000,
  parameter int unsigned BURST_CYC    = 20000,
  parameter int unsigned CYC_PER_CM   = 5800,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = 3_800_000,
  parameter int unsigned GUARD_CYC    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [9:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig,
  output logic [7:0] ping_cnt
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter serves every timed phase, so it is sized for the longest one.
  localparam int unsigned CNT_MAXV = max2(max2(TIMEOUT_CYC, BURST_CYC),
                                          max2(max2(GUARD_CYC, CYC_PER_CM), TRIG_MIN_CYC));
  localparam int CNT_W = $clog2(CNT_MAXV + 1);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, GUARD} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state;
  logic             trig_m, trig_s;
  logic [1:0]       sync_vld;
  logic             armed;
  logic [CNT_W-1:0] cnt, sub_cnt;
  logic [9:0]       lat_cm, cm_left;
  logic             lat_oor;
  logic             cm_done, echo_done;

  // Synchronizer; sync_vld marks when trig_s carries a post-reset sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      trig_m   <= trig;
      trig_s   <= trig_m;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  always_comb begin
    cm_done = (sub_cnt == CNT_W'(CYC_PER_CM - 1)) && (cm_left == 10'd1);
`ifdef SONIC_ECHO_TIMEOUT_EN
    echo_done = lat_oor ? (cnt == CNT_W'(TIMEOUT_CYC - 1)) : cm_done;
`else
    echo_done = cm_done;
`endif
  end

  // armed is set only after trig_s has been seen low while idle, so a level
  // already high at reset release or left over from a ping is never an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      cnt        <= '0;
      sub_cnt    <= '0;
      lat_cm     <= '0;
      cm_left    <= '0;
      lat_oor    <= 1'b0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
      ping_cnt   <= '0;
    end else begin
      short_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && trig_s) begin
            state <= TRIG_HI;
            busy  <= 1'b1;
            cnt   <= '0;
            armed <= 1'b0;
          end else if (sync_vld[1] && !trig_s) begin
            armed <= 1'b1;
          end
        end
        TRIG_HI: begin
          if (trig_s) begin
            cnt <= sat_inc(cnt);
          end else if (cnt >= CNT_W'(TRIG_MIN_CYC)) begin
            state   <= BURST;
            cnt     <= '0;
            lat_cm  <= distance_cm;
            lat_oor <= (distance_cm == '0) || (distance_cm > 10'(MAX_CM));
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            short_trig <= 1'b1;
          end
        end
        BURST: begin
          if (cnt == CNT_W'(BURST_CYC - 1)) begin
            cnt     <= '0;
            sub_cnt <= '0;
            cm_left <= lat_cm;
`ifdef SONIC_ECHO_TIMEOUT_EN
            state <= ECHO;
            echo  <= 1'b1;
`else
            if (lat_oor) begin
              state <= GUARD;
            end else begin
              state <= ECHO;
              echo  <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ECHO: begin
          // Width is lat_cm * CYC_PER_CM built from a cm counter and a per-cm sub-counter.
          if (echo_done) begin
            state    <= GUARD;
            echo     <= 1'b0;
            cnt      <= '0;
            ping_cnt <= ping_cnt + 1'b1;
          end else if (lat_oor) begin
            cnt <= cnt + 1'b1;
          end else if (sub_cnt == CNT_W'(CYC_PER_CM - 1)) begin
            sub_cnt <= '0;
            cm_left <= cm_left - 1'b1;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        GUARD: begin
          if (cnt == CNT_W'(GUARD_CYC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          echo  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Bench for sonic_echo_responder with time-scaled constants; a window model predicts every output each cycle.
module tb_sonic_echo_responder;

  localparam int TMIN  = 10;
  localparam int BURST = 20;
  localparam int CPC   = 6;
  localparam int MAXCM = 400;
  localparam int TOUT  = 50;
  localparam int GUARD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [9:0] distance_cm = '0;
  logic       echo, busy, short_trig;
  logic [7:0] ping_cnt;

  sonic_echo_responder #(
    .TRIG_MIN_CYC(TMIN), .BURST_CYC(BURST), .CYC_PER_CM(CPC),
    .MAX_CM(MAXCM), .TIMEOUT_CYC(TOUT), .GUARD_CYC(GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .short_trig(short_trig), .ping_cnt(ping_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails = 0;

  // Model: output windows in edge numbers; value after edge N is seen at the negedge where cyc==N.
  int m_b0 = 0, m_b1 = 0, m_r = 0, m_f = 0, m_s = -1, m_rst = -1, m_ping = 0;
  bit m_inc = 1'b0;
  int fall_cyc = 0;

  logic e_echo, e_busy, e_short;
  logic echo_q = 1'b0;
  int rise_cyc = 0, cur_w = 0, last_w = 0, pulses = 0, short_seen = 0;

  always @(negedge clk) begin
    if (m_inc && cyc == m_f) m_ping = (m_ping + 1) % 256;
    if (cyc == m_rst) m_ping = 0;
    if (cyc >= 1) begin
      e_echo  = (cyc >= m_r) && (cyc < m_f);
      e_busy  = (cyc >= m_b0) && (cyc < m_b1);
      e_short = (cyc == m_s);
      vectors++;
      if (echo !== e_echo || busy !== e_busy || short_trig !== e_short || ping_cnt !== 8'(m_ping)) begin
        fails++;
        if (fails <= 20)
          $display("FAIL cycle %0d echo/busy/short_trig/ping_cnt: got %b/%b/%b/%0d, required %b/%b/%b/%0d",
                   cyc, echo, busy, short_trig, ping_cnt, e_echo, e_busy, e_short, m_ping);
      end
      if (echo === 1'b1 && echo_q !== 1'b1) begin
        rise_cyc = cyc;
        cur_w = 0;
        pulses++;
      end
      if (echo === 1'b1) cur_w++;
      if (echo !== 1'b1 && echo_q === 1'b1) last_w = cur_w;
      if (short_trig === 1'b1) short_seen++;
      echo_q = echo;
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic start_ping(input int h, input int cm);
    int n, m;
    @(posedge clk); #1;
    n = cyc;
    trig = 1'b1;
    distance_cm = 10'(cm);
    m_b0 = n + 3;
    m_b1 = 32'h7fff_ffff;
    m_s = -1;
    m_inc = 1'b0;
    repeat (h) @(posedge clk);
    #1;
    m = cyc;
    fall_cyc = m;
    trig = 1'b0;
    if (h > TMIN) begin
      if (cm >= 1 && cm <= MAXCM) begin
        m_r = m + 3 + BURST;
        m_f = m_r + cm * CPC;
        m_inc = 1'b1;
        m_b1 = m_f + GUARD;
      end else begin
`ifdef SONIC_ECHO_TIMEOUT_EN
        m_r = m + 3 + BURST;
        m_f = m_r + TOUT;
        m_inc = 1'b1;
        m_b1 = m_f + GUARD;
`else
        m_r = 0;
        m_f = 0;
        m_b1 = m + 3 + BURST + GUARD;
`endif
      end
    end else begin
      m_s = m + 3;
      m_b1 = m + 3;
    end
  endtask

  task automatic wait_idle();
    int lim;
    lim = cyc + 5000;
    while (cyc < m_b1 + 3 && cyc < lim) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (cyc >= lim) begin
      fails++;
      $display("FAIL wait_idle timeout at cycle %0d, required end by %0d", cyc, m_b1 + 3);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int k, input logic trig_val);
    int c;
    @(posedge clk); #1;
    c = cyc;
    rst_n = 1'b0;
    trig = trig_val;
    m_rst = c + 1;
    if (m_b1 > c + 1) m_b1 = c + 1;
    if (m_f > c + 1) begin
      m_inc = 1'b0;
      m_f = c + 1;
    end
    if (m_r > c + 1) m_r = c + 1;
    if (m_s > c) m_s = -1;
    repeat (k) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int p0, s0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_lit("reset_ping_cnt", int'(ping_cnt), 0);
    check_lit("reset_busy", int'(busy), 0);
    check_lit("reset_echo", int'(echo), 0);
    repeat (3) @(posedge clk);

    // Nominal ping at 40 cm
    start_ping(12, 40);
    wait_idle();
    check_lit("cm40_width", last_w, 240);
    check_lit("cm40_rise_edge_after_fall", rise_cyc - fall_cyc, 23);
    check_lit("cm40_ping_cnt", int'(ping_cnt), 1);

    // Short trigger
    p0 = pulses; s0 = short_seen;
    start_ping(5, 40);
    wait_idle();
    check_lit("short_pulses", short_seen - s0, 1);
    check_lit("short_no_echo", pulses - p0, 0);
    check_lit("short_ping_cnt", int'(ping_cnt), 1);

    // Qualification boundary, minimum distance, saturating high-time counter
    start_ping(TMIN + 1, 1);
    wait_idle();
    check_lit("cm1_width", last_w, 6);
    s0 = short_seen;
    start_ping(TMIN - 1, 1);
    wait_idle();
    check_lit("below_min_short", short_seen - s0, 1);
    start_ping(100, 2);
    wait_idle();
    check_lit("long_trig_cm2_width", last_w, 12);

    // Out-of-range distances
    p0 = pulses;
    start_ping(12, 0);
    wait_idle();
    start_ping(12, 401);
    wait_idle();
`ifdef SONIC_ECHO_TIMEOUT_EN
    check_lit("oor_pulses", pulses - p0, 2);
    check_lit("oor_width", last_w, 50);
    check_lit("oor_ping_cnt", int'(ping_cnt), 5);
`else
    check_lit("oor_pulses", pulses - p0, 0);
    check_lit("oor_ping_cnt", int'(ping_cnt), 3);
`endif

    // Distance change and trig activity during ECHO are ignored
    p0 = pulses;
    start_ping(12, 100);
    wait_until(m_r + 50);
    distance_cm = 10'd5;
    trig = 1'b1;
    repeat (20) @(posedge clk);
    #1 trig = 1'b0;
    wait_idle();
    check_lit("cm100_width", last_w, 600);
    check_lit("cm100_single_ping", pulses - p0, 1);

    start_ping(12, 400);
    wait_idle();
    check_lit("cm400_width", last_w, 2400);

    // Reset in the middle of ECHO
    start_ping(12, 100);
    wait_until(m_r + 30);
    do_reset(1, 1'b0);
    @(negedge clk);
    check_lit("midreset_echo", int'(echo), 0);
    check_lit("midreset_busy", int'(busy), 0);
    check_lit("midreset_ping_cnt", int'(ping_cnt), 0);
    repeat (3) @(posedge clk);
    start_ping(12, 1);
    wait_idle();
    check_lit("after_reset_width", last_w, 6);
    check_lit("after_reset_ping_cnt", int'(ping_cnt), 1);

    // Trig already high at reset release is not an edge
    p0 = pulses;
    do_reset(2, 1'b1);
    repeat (20) @(posedge clk);
    #1 trig = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_lit("held_trig_no_ping", pulses - p0, 0);
    check_lit("held_trig_ping_cnt", int'(ping_cnt), 0);

    // 256 pings wrap the counter
    for (int i = 0; i < 256; i++) begin
      start_ping(12, 1);
      wait_idle();
      if (i == 254) check_lit("ping_cnt_255", int'(ping_cnt), 255);
    end
    check_lit("ping_cnt_wrap", int'(ping_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
